// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable little-endian data memory behind a valid/ready
// request channel. Handles byte/half/word accesses with sign/zero extension,
// programmable wait states per beat, and optional two-beat split of accesses
// that straddle a word boundary.
module dmem_ctrl #(
    parameter int unsigned MEM_BYTES      = 4096,
    parameter int unsigned WAIT_CYCLES    = 0,
    parameter bit          MISALIGN_SPLIT = 1'b1,
    parameter string       INIT_FILE      = "DMEM_MEMORY_IN.hex",
    parameter string       OUT_FILE       = "DMEM_MEMORY_OUT.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW        = $clog2(MEM_BYTES);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT1,
        ST_BEAT2
    } state_t;

    logic [7:0] mem [MEM_BYTES];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        beat_active;
    logic        beat_last;

    // Captured request
    logic [AW-1:0] addr_q;
    logic [2:0]    nbytes_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic          cross_q;
    logic          second_q;
    logic [31:0]   ld_q;

    // Request decode
    logic [2:0]  req_nbytes;
    logic [32:0] req_end;
    logic        req_oob;
    logic        req_cross;
    logic        req_err;

    // Beat datapath
    logic          in_beat2;
    logic [3:0]    sel;
    logic [AW-1:0] baddr [4];
    logic [31:0]   assembled;
    logic [31:0]   ext;

    assign req_ready = (state_q == ST_IDLE) && !rst;

    // Decode size, bounds and word crossing of the incoming request
    always_comb begin
        unique case (req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_end   = {1'b0, req_addr} + 33'(req_nbytes);
        req_oob   = req_end > 33'(MEM_BYTES);
        req_cross = ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;
        req_err   = (req_size == 2'b11) || req_oob || (req_cross && !MISALIGN_SPLIT);
    end

    // FSM state and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; WAIT is bypassed entirely when no wait states are configured
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        beat_active = 1'b0;
        beat_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_BEAT1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = second_q ? ST_BEAT2 : ST_BEAT1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_BEAT1: begin
                beat_active = 1'b1;
                if (cross_q && !err_q) begin
                    if (WAIT_CYCLES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_BEAT2;
                    end
                end else begin
                    beat_last = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_BEAT2: begin
                beat_active = 1'b1;
                beat_last   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select the request bytes that fall in the current beat's word and merge read data
    always_comb begin
        in_beat2  = (state_q == ST_BEAT2);
        assembled = ld_q;
        sel       = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            baddr[j] = addr_q + AW'(j);
            sel[j]   = beat_active && !err_q && (j < 32'(nbytes_q)) &&
                       (((32'(addr_q[1:0]) + j) >= 32'd4) == in_beat2);
            if (sel[j]) begin
                assembled[8*j +: 8] = mem[baddr[j]];
            end
        end
    end

    // Shape the final response word: error pattern, zero for stores, extended load
    always_comb begin
        ext = assembled;
        if (err_q) begin
            ext = '1;
        end else if (we_q) begin
            ext = '0;
        end else begin
            unique case (size_q)
                2'b00:   ext = uns_q ? {24'd0, assembled[7:0]}
                                     : {{24{assembled[7]}}, assembled[7:0]};
                2'b01:   ext = uns_q ? {16'd0, assembled[15:0]}
                                     : {{16{assembled[15]}}, assembled[15:0]};
                default: ext = assembled;
            endcase
        end
    end

    // Capture the request at accept and accumulate load bytes across beats
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            nbytes_q <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
            second_q <= 1'b0;
            ld_q     <= '0;
        end else if (accept) begin
            addr_q   <= req_addr[AW-1:0];
            nbytes_q <= req_nbytes;
            size_q   <= req_size;
            we_q     <= req_we;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            cross_q  <= req_cross;
            second_q <= 1'b0;
            ld_q     <= '0;
        end else if (beat_active) begin
            ld_q <= assembled;
            if (state_q == ST_BEAT1) begin
                second_q <= 1'b1;
            end
        end
    end

    // One-cycle response pulse on the final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= beat_last;
            if (beat_last) begin
                resp_err   <= err_q;
                resp_rdata <= ext;
            end
        end
    end

    // Store bytes of the current beat; a reset edge suppresses the write, array is never cleared
    always_ff @(posedge clk) begin
        if (!rst && we_q) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (sel[j]) begin
                    mem[baddr[j]] <= wdata_q[8*j +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl across three configurations
// (A: no wait, split; B: 2 waits, split; C: 1 wait, no split).
module tb_dmem_ctrl;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;
    localparam int unsigned MB  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [31:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        resp_valid   [3];
    logic [31:0] resp_rdata   [3];
    logic        resp_err     [3];

    dmem_ctrl #(.MEM_BYTES(MB), .WAIT_CYCLES(0), .MISALIGN_SPLIT(1'b1),
                .INIT_FILE(""), .OUT_FILE("")) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    dmem_ctrl #(.MEM_BYTES(MB), .WAIT_CYCLES(2), .MISALIGN_SPLIT(1'b1),
                .INIT_FILE(""), .OUT_FILE("")) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    dmem_ctrl #(.MEM_BYTES(MB), .WAIT_CYCLES(1), .MISALIGN_SPLIT(1'b0),
                .INIT_FILE(""), .OUT_FILE("")) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
        .req_unsigned(req_unsigned[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   cyc        = 0;
    int   checks     = 0;
    int   fails      = 0;
    int   acc_cnt[3]  = '{0, 0, 0};
    int   resp_cnt[3] = '{0, 0, 0};
    int   issued[3]   = '{0, 0, 0};
    int   stall[3]    = '{0, 0, 0};
    logic rst_prev   = 1'b1;
    bit   done       = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Cycle counter and handshake counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (req_valid[d] === 1'b1 && req_ready[d] === 1'b1) acc_cnt[d] <= acc_cnt[d] + 1;
        end
    end

    // Monitor: reset-state checks, scoreboard pops, timeouts and end-of-test summary
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d expected below 20000", cyc);
            $fatal(1);
        end
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rst_ready[%0d]", d), 32'(req_ready[d]), 32'd0);
                chk($sformatf("rst_resp_valid[%0d]", d), 32'(resp_valid[d]), 32'd0);
            end
        end else if (rst_prev) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("post_rst_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
                chk($sformatf("post_rst_rdata[%0d]", d), resp_rdata[d], 32'd0);
                chk($sformatf("post_rst_err[%0d]", d), 32'(resp_err[d]), 32'd0);
            end
        end
        rst_prev = rst;
        for (int d = 0; d < 3; d++) begin
            if (resp_valid[d] === 1'b1) begin
                resp_cnt[d]++;
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_resp[%0d]", d), 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("resp_dut[%0d]", d), 32'(d), 32'(e.dut));
                    chk($sformatf("rdata[%0d]", d), resp_rdata[d], e.rdata);
                    chk($sformatf("err[%0d]", d), 32'(resp_err[d]), 32'(e.err));
                    chk($sformatf("latency_cycle[%0d]", d), 32'(cyc), 32'(e.due));
                end
            end
            if (req_valid[d] === 1'b1 && req_ready[d] !== 1'b1 && !rst) stall[d]++;
            else stall[d] = 0;
            if (stall[d] == 40) chk($sformatf("ready_timeout[%0d]", d), 32'd1, 32'd0);
        end
        if (sbq.size() > 0 && cyc > sbq[0].due) begin
            e = sbq.pop_front();
            chk($sformatf("resp_timeout[%0d]", e.dut), 32'(cyc), 32'(e.due));
        end
        if (done) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("accepts[%0d]", d), 32'(acc_cnt[d]), 32'(issued[d] + ((d == 1) ? 1 : 0)));
                chk($sformatf("resps[%0d]", d), 32'(resp_cnt[d]), 32'(issued[d]));
            end
            chk("sb_empty", 32'(sbq.size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
    end

    // Drive one request (called at posedge+1); push expectation once ready is seen
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input bit push = 1'b1, input bit hold = 1'b0);
        exp_t e;
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_wdata[d]    = wdata;
        for (int i = 0; i < 50 && req_ready[d] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (req_ready[d] !== 1'b1) begin
            req_valid[d] = 1'b0;
            return;
        end
        if (push) begin
            e.dut   = d;
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.due   = cyc + 1 + lat;
            sbq.push_back(e);
            issued[d]++;
        end
        @(posedge clk); #1;
        if (!hold) req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Directed stimulus
    initial begin
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_size[d] = SZ_W; req_unsigned[d] = 1'b0; req_wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // A: word store/load, byte store with sign/zero-extended reads
        issue(0, 1'b1, 32'h10, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        issue(0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        issue(0, 1'b1, 32'h13, SZ_B, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 1);
        issue(0, 1'b0, 32'h13, SZ_B, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 1);
        issue(0, 1'b0, 32'h13, SZ_B, 1'b1, 32'h0, 32'h00000080, 1'b0, 1);
        issue(0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, 1);
        issue(0, 1'b0, 32'h11, SZ_H, 1'b0, 32'h0, 32'hFFFFADBE, 1'b0, 1);
        issue(0, 1'b0, 32'h12, SZ_H, 1'b1, 32'h0, 32'h000080AD, 1'b0, 1);
        // A: split accesses with no wait states
        issue(0, 1'b1, 32'h14, SZ_W, 1'b0, 32'h04030201, 32'h0, 1'b0, 1);
        issue(0, 1'b0, 32'h12, SZ_W, 1'b0, 32'h0, 32'h020180AD, 1'b0, 2);
        issue(0, 1'b1, 32'h17, SZ_H, 1'b0, 32'h1234CAFE, 32'h0, 1'b0, 2);
        issue(0, 1'b0, 32'h14, SZ_W, 1'b0, 32'h0, 32'hFE030201, 1'b0, 1);
        issue(0, 1'b0, 32'h18, SZ_B, 1'b1, 32'h0, 32'h000000CA, 1'b0, 1);
        // A: top-of-array boundary and error cases
        issue(0, 1'b1, MB - 4, SZ_W, 1'b0, 32'h01020304, 32'h0, 1'b0, 1);
        issue(0, 1'b0, MB - 4, SZ_W, 1'b0, 32'h0, 32'h01020304, 1'b0, 1);
        issue(0, 1'b0, MB - 2, SZ_H, 1'b0, 32'h0, 32'h00000102, 1'b0, 1);
        issue(0, 1'b0, MB - 1, SZ_B, 1'b0, 32'h0, 32'h00000001, 1'b0, 1);
        issue(0, 1'b0, MB - 2, SZ_W, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
        issue(0, 1'b1, MB, SZ_B, 1'b0, 32'h55, 32'hFFFFFFFF, 1'b1, 1);
        issue(0, 1'b0, 32'hFFFFFFFE, SZ_H, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
        issue(0, 1'b1, 32'h10, SZ_X, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1);
        issue(0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, 1);
        // A: back-to-back loads with req_valid held high
        issue(0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, 1, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h10, SZ_B, 1'b1, 32'h0, 32'h000000EF, 1'b0, 1, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h11, SZ_B, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0, 1, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h10, SZ_H, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
        drain();

        // C: word-crossing is an error without split; memory must stay intact
        issue(2, 1'b1, 32'h00, SZ_W, 1'b0, 32'h12345678, 32'h0, 1'b0, 2);
        issue(2, 1'b1, 32'h03, SZ_H, 1'b0, 32'h0000AAAA, 32'hFFFFFFFF, 1'b1, 2);
        issue(2, 1'b0, 32'h03, SZ_H, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 2);
        issue(2, 1'b0, 32'h01, SZ_W, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 2);
        issue(2, 1'b0, 32'h00, SZ_W, 1'b0, 32'h0, 32'h12345678, 1'b0, 2);
        issue(2, 1'b1, 32'h01, SZ_H, 1'b0, 32'h0000BBBB, 32'h0, 1'b0, 2);
        issue(2, 1'b0, 32'h00, SZ_W, 1'b0, 32'h0, 32'h12BBBB78, 1'b0, 2);
        drain();

        // B: split store with two wait states per beat
        issue(1, 1'b1, 32'h20, SZ_W, 1'b0, 32'hA0A1A2A3, 32'h0, 1'b0, 3);
        issue(1, 1'b1, 32'h24, SZ_W, 1'b0, 32'hB0B1B2B3, 32'h0, 1'b0, 3);
        issue(1, 1'b1, 32'h22, SZ_W, 1'b0, 32'h11223344, 32'h0, 1'b0, 6);
        issue(1, 1'b0, 32'h20, SZ_W, 1'b0, 32'h0, 32'h3344A2A3, 1'b0, 3);
        issue(1, 1'b0, 32'h24, SZ_W, 1'b0, 32'h0, 32'hB0B11122, 1'b0, 3);
        issue(1, 1'b0, 32'h22, SZ_W, 1'b0, 32'h0, 32'h11223344, 1'b0, 6);
        issue(1, 1'b0, 32'h23, SZ_H, 1'b0, 32'h0, 32'h00002233, 1'b0, 6);
        // B: reset during the second WAIT of a split store
        issue(1, 1'b1, 32'h40, SZ_W, 1'b0, 32'h55667788, 32'h0, 1'b0, 3);
        issue(1, 1'b1, 32'h44, SZ_W, 1'b0, 32'h99AABBCC, 32'h0, 1'b0, 3);
        drain();
        issue(1, 1'b1, 32'h42, SZ_W, 1'b0, 32'h11223344, 32'h0, 1'b0, 6, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h40, SZ_W, 1'b0, 32'h0, 32'h33447788, 1'b0, 3);
        issue(1, 1'b0, 32'h44, SZ_W, 1'b0, 32'h0, 32'h99AABBCC, 1'b0, 3);
        drain();

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary_not_reached: monitor did not finish");
        $fatal(1);
    end

endmodule
